// File: rtl/divider_prog.sv
// divider_prog: programmable clock divider that reloads its divisor only at a period boundary.
// Square-wave output is compiled in only when DIVIDER_SQUARE_EN is defined.
module divider_prog #(
    parameter int W = 24,
    parameter int M = 12_000_000
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] div_in,
    input  logic         mode,
    output logic         clk_out,
    output logic         busy,
    output logic         ack
);

    localparam logic [W-1:0] DIV_RST = W'(M);
    localparam logic [W-1:0] DIV_MIN = W'(2);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_next;
    logic [W-1:0] div_act;
    logic [W-1:0] div_next;
    logic [W-1:0] div_pend;
    logic [W-1:0] pend_next;
    logic [W-1:0] div_clamp;
    logic         busy_next;
    logic         out_next;
    logic         wrap;
    logic         apply;
    logic         apply_q;

    assign div_clamp = (div_in < DIV_MIN) ? DIV_MIN : div_in;
    assign wrap      = en && (cnt == div_act - W'(1));

    // A pending divisor lands on a wrap, or immediately while counting is paused.
    assign apply     = busy && (wrap || !en);

    always_comb begin
        cnt_next  = cnt;
        div_next  = div_act;
        pend_next = div_pend;
        busy_next = busy;
        if (en) begin
            cnt_next = wrap ? '0 : cnt + W'(1);
        end
        if (load) begin
            pend_next = div_clamp;
        end
        if (apply) begin
            div_next  = load ? div_clamp : div_pend;
            cnt_next  = '0;
            busy_next = 1'b0;
        end else if (load) begin
            busy_next = 1'b1;
        end
    end

`ifdef DIVIDER_SQUARE_EN
    always_comb begin
        out_next = wrap;
        if (mode) begin
            out_next = en ? (cnt_next < (div_next >> 1)) : clk_out;
        end
    end
`else
    logic mode_unused;
    assign mode_unused = mode;

    always_comb begin
        out_next = wrap;
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            div_act  <= DIV_RST;
            div_pend <= DIV_RST;
            busy     <= 1'b0;
            apply_q  <= 1'b0;
            ack      <= 1'b0;
            clk_out  <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            div_act  <= div_next;
            div_pend <= pend_next;
            busy     <= busy_next;
            apply_q  <= apply;
            ack      <= apply_q;
            clk_out  <= out_next;
        end
    end

endmodule

// File: tb/tb_divider_prog.sv
// tb_divider_prog: directed checks of divider_prog with M=5, W=8.
// Square-mode expectations follow DIVIDER_SQUARE_EN when it is defined.
module tb_divider_prog;

`ifdef DIVIDER_SQUARE_EN
    localparam bit SQ = 1'b1;
`else
    localparam bit SQ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] div_in = 8'd0;
    logic       mode = 1'b0;
    logic       clk_out;
    logic       busy;
    logic       ack;

    int tests = 0;
    int fails = 0;

    divider_prog #(.W(8), .M(5)) dut (
        .clk(clk),
        .rstn(rstn),
        .en(en),
        .load(load),
        .div_in(div_in),
        .mode(mode),
        .clk_out(clk_out),
        .busy(busy),
        .ack(ack)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rstn = 1'b0;
        #1;
        tests++;
        if (clk_out !== 1'b0) begin fails++; $display("FAIL reset clk_out got=%b exp=0", clk_out); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset busy got=%b exp=0", busy); end
        tests++;
        if (ack !== 1'b0) begin fails++; $display("FAIL reset ack got=%b exp=0", ack); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        en   = 1'b1;
    endtask

    task automatic test_pulse();
        logic e;
        for (int k = 1; k <= 15; k++) begin
            tick();
            e = (k % 5 == 0);
            tests++;
            if (clk_out !== e) begin fails++; $display("FAIL pulse k=%0d clk_out got=%b exp=%b", k, clk_out, e); end
            tests++;
            if (busy !== 1'b0) begin fails++; $display("FAIL pulse k=%0d busy got=%b exp=0", k, busy); end
        end
    endtask

    task automatic test_load();
        logic [0:8] eo;
        logic [0:8] eb;
        logic [0:8] ea;
        eo = 9'b001001001;
        eb = 9'b110000000;
        ea = 9'b000100000;
        tick();
        load = 1'b1;
        div_in = 8'd3;
        tick();
        load = 1'b0;
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL load busy_set got=%b exp=1", busy); end
        for (int i = 0; i < 9; i++) begin
            tick();
            tests++;
            if (clk_out !== eo[i]) begin fails++; $display("FAIL load i=%0d clk_out got=%b exp=%b", i, clk_out, eo[i]); end
            tests++;
            if (busy !== eb[i]) begin fails++; $display("FAIL load i=%0d busy got=%b exp=%b", i, busy, eb[i]); end
            tests++;
            if (ack !== ea[i]) begin fails++; $display("FAIL load i=%0d ack got=%b exp=%b", i, ack, ea[i]); end
        end
    endtask

    task automatic test_overwrite();
        logic [0:9] eo;
        logic [0:9] ea;
        int acks;
        eo = 10'b1000000001;
        ea = 10'b0100000000;
        acks = 0;
        load = 1'b1;
        div_in = 8'd7;
        tick();
        div_in = 8'd9;
        tick();
        load = 1'b0;
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL overwrite busy_set got=%b exp=1", busy); end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack === 1'b1) acks++;
            tests++;
            if (clk_out !== eo[i]) begin fails++; $display("FAIL overwrite i=%0d clk_out got=%b exp=%b", i, clk_out, eo[i]); end
            tests++;
            if (ack !== ea[i]) begin fails++; $display("FAIL overwrite i=%0d ack got=%b exp=%b", i, ack, ea[i]); end
            tests++;
            if (busy !== 1'b0) begin fails++; $display("FAIL overwrite i=%0d busy got=%b exp=0", i, busy); end
        end
        tests++;
        if (acks != 1) begin fails++; $display("FAIL overwrite ack_count got=%0d exp=1", acks); end
    endtask

    task automatic test_clamp();
        logic [0:3] eo;
        logic [0:3] ea;
        int n;
        eo = 4'b0101;
        ea = 4'b1000;
        n = 0;
        load = 1'b1;
        div_in = 8'd0;
        tick();
        load = 1'b0;
        while (busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (n != 8) begin fails++; $display("FAIL clamp apply_delay got=%0d exp=8", n); end
        tests++;
        if (clk_out !== 1'b1) begin fails++; $display("FAIL clamp wrap clk_out got=%b exp=1", clk_out); end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (clk_out !== eo[i]) begin fails++; $display("FAIL clamp i=%0d clk_out got=%b exp=%b", i, clk_out, eo[i]); end
            tests++;
            if (ack !== ea[i]) begin fails++; $display("FAIL clamp i=%0d ack got=%b exp=%b", i, ack, ea[i]); end
        end
    endtask

    task automatic test_simul();
        logic e;
        load = 1'b1;
        div_in = 8'd4;
        tick();
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL simul busy_set got=%b exp=1", busy); end
        en = 1'b0;
        div_in = 8'd6;
        tick();
        load = 1'b0;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL simul busy_apply got=%b exp=0", busy); end
        tests++;
        if (clk_out !== 1'b0) begin fails++; $display("FAIL simul clk_out_paused got=%b exp=0", clk_out); end
        en = 1'b1;
        tick();
        tests++;
        if (ack !== 1'b1) begin fails++; $display("FAIL simul ack got=%b exp=1", ack); end
        for (int k = 2; k <= 6; k++) begin
            tick();
            e = (k == 6);
            tests++;
            if (clk_out !== e) begin fails++; $display("FAIL simul k=%0d clk_out got=%b exp=%b", k, clk_out, e); end
            tests++;
            if (ack !== 1'b0) begin fails++; $display("FAIL simul k=%0d ack got=%b exp=0", k, ack); end
            tests++;
            if (busy !== 1'b0) begin fails++; $display("FAIL simul k=%0d busy got=%b exp=0", k, busy); end
        end
    endtask

    task automatic test_square();
        logic e;
        int c;
        int n;
        mode = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            c = k % 6;
            e = SQ ? (c < 3) : (c == 0);
            tests++;
            if (clk_out !== e) begin fails++; $display("FAIL square6 k=%0d clk_out got=%b exp=%b", k, clk_out, e); end
        end
        load = 1'b1;
        div_in = 8'd7;
        tick();
        load = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (n != 5) begin fails++; $display("FAIL square load7 apply_delay got=%0d exp=5", n); end
        tests++;
        if (clk_out !== 1'b1) begin fails++; $display("FAIL square7 apply clk_out got=%b exp=1", clk_out); end
        for (int k = 1; k <= 14; k++) begin
            tick();
            c = k % 7;
            e = SQ ? (c < 3) : (c == 0);
            tests++;
            if (clk_out !== e) begin fails++; $display("FAIL square7 k=%0d clk_out got=%b exp=%b", k, clk_out, e); end
        end
        en = 1'b0;
        tick();
        e = SQ;
        tests++;
        if (clk_out !== e) begin fails++; $display("FAIL square hold clk_out got=%b exp=%b", clk_out, e); end
        en = 1'b1;
        tick();
        e = SQ;
        tests++;
        if (clk_out !== e) begin fails++; $display("FAIL square resume clk_out got=%b exp=%b", clk_out, e); end
        mode = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            e = (k == 6);
            tests++;
            if (clk_out !== e) begin fails++; $display("FAIL modechg k=%0d clk_out got=%b exp=%b", k, clk_out, e); end
        end
    endtask

    task automatic test_reset_pending();
        logic e;
        load = 1'b1;
        div_in = 8'd3;
        tick();
        load = 1'b0;
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL rstpend busy_set got=%b exp=1", busy); end
        #3 rstn = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL rstpend busy got=%b exp=0", busy); end
        tests++;
        if (clk_out !== 1'b0) begin fails++; $display("FAIL rstpend clk_out got=%b exp=0", clk_out); end
        tests++;
        if (ack !== 1'b0) begin fails++; $display("FAIL rstpend ack got=%b exp=0", ack); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            e = (k % 5 == 0);
            tests++;
            if (clk_out !== e) begin fails++; $display("FAIL rstpend k=%0d clk_out got=%b exp=%b", k, clk_out, e); end
            tests++;
            if (ack !== 1'b0) begin fails++; $display("FAIL rstpend k=%0d ack got=%b exp=0", k, ack); end
            tests++;
            if (busy !== 1'b0) begin fails++; $display("FAIL rstpend k=%0d busy got=%b exp=0", k, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_pulse();
        test_load();
        test_overwrite();
        test_clamp();
        test_simul();
        test_square();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
